vector_mem_sequencer: RTL and testbench

Multi-cycle sequencer for RVV unit-stride and strided vector loads and stores (`vle*`/`vse*`, `vlse*`/`vsse*`). It sits directly downstream of the decode/data-path stage and upstream of the single-port main memory and vector register file. Decode hands it one latched request. The block then issues one memory access per element cycle, holds the PC via `busy`, and for loads writes the assembled destination register back in one shot.

---
 rtl/vector_mem_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// RVV unit-stride / strided vector load-store sequencer.
// Issues one single-port memory access per element and writes the load result back in one shot.
module vector_mem_sequencer #(
  parameter int unsigned VLEN = 128
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [31:0]     base_address,
  input  logic [31:0]     stride,
  input  logic [1:0]      mop,
  input  logic            vm,
  input  logic [4:0]      vreg_address,
  input  logic [2:0]      vsew,
  input  logic [31:0]     vl,
  input  logic [31:0]     vstart,
  input  logic [VLEN-1:0] v_src,
  input  logic [VLEN-1:0] v0_mask,
  input  logic [31:0]     MEM_read_data,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [31:0]     MEM_read_address,
  output logic            MEM_write_enable,
  output logic [31:0]     MEM_write_address,
  output logic [31:0]     MEM_write_data,
  output logic [3:0]      MEM_write_strobe,
  output logic            VREG_write_enable,
  output logic [4:0]      VREG_write_address,
  output logic [VLEN-1:0] VREG_write_data
);

  localparam int unsigned IW = $clog2(VLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [VLEN-1:0] buf_q, buf_d;
  logic [31:0]     idx_q, idx_d;
  logic            err_q, err_d;

  logic            store_q, strided_q, vm_q;
  logic [VLEN-1:0] mask_q;
  logic [4:0]      vd_q;
  logic [1:0]      sew_q;
  logic [31:0]     vl_q, base_q, stride_q;
  logic            accept;

  // Element datapath, all derived from the latched request and current index.
  logic [31:0]     elem_off, addr, ew_mask32, bit_off, rd_elem, st_elem, max_el;
  logic [3:0]      strb_base;
  logic [4:0]      lane_sh;
  logic            misaligned, active, bad_req;
  logic [VLEN-1:0] elem_mask_v, ld_buf;

  always_comb begin
    elem_off   = strided_q ? (idx_q * stride_q) : (idx_q << sew_q);
    addr       = base_q + elem_off;
    lane_sh    = {addr[1:0], 3'b000};
    bit_off    = idx_q << (32'd3 + 32'(sew_q));
    ew_mask32  = 32'h0000_00FF;
    strb_base  = 4'b0001;
    misaligned = 1'b0;
    case (sew_q)
      2'd1: begin
        ew_mask32  = 32'h0000_FFFF;
        strb_base  = 4'b0011;
        misaligned = addr[0];
      end
      2'd2: begin
        ew_mask32  = 32'hFFFF_FFFF;
        strb_base  = 4'b1111;
        misaligned = (addr[1:0] != 2'b00);
      end
      default: ;
    endcase
    active      = vm_q | mask_q[idx_q[IW-1:0]];
    rd_elem     = (MEM_read_data >> lane_sh) & ew_mask32;
    elem_mask_v = VLEN'(ew_mask32) << bit_off;
    ld_buf      = (buf_q & ~elem_mask_v) | (VLEN'(rd_elem) << bit_off);
    st_elem     = 32'(buf_q >> bit_off) & ew_mask32;
    max_el      = 32'(VLEN) >> (32'd3 + 32'(vsew));
    bad_req     = (vsew > 3'd2) || mop[0] || (vl > max_el);
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      store_q   <= 1'b0;
      strided_q <= 1'b0;
      vm_q      <= 1'b0;
      mask_q    <= '0;
      vd_q      <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      base_q    <= '0;
      stride_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (accept) begin
        store_q   <= is_store;
        strided_q <= mop[1];
        vm_q      <= vm;
        mask_q    <= v0_mask;
        vd_q      <= vreg_address;
        sew_q     <= vsew[1:0];
        vl_q      <= vl;
        base_q    <= base_address;
        stride_q  <= stride;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    buf_d              = buf_q;
    idx_d              = idx_q;
    err_d              = err_q;
    accept             = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    error              = 1'b0;
    MEM_read_address   = '0;
    MEM_write_enable   = 1'b0;
    MEM_write_address  = '0;
    MEM_write_data     = '0;
    MEM_write_strobe   = '0;
    VREG_write_enable  = 1'b0;
    VREG_write_address = '0;
    VREG_write_data    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          buf_d  = v_src;
          idx_d  = vstart;
          err_d  = bad_req;
          if (bad_req || (vstart >= vl)) state_d = S_DONE;
          else                           state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Masked-off elements skip the alignment check as they never touch memory.
        if (active && misaligned) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          if (active) begin
            if (store_q) begin
              MEM_write_enable  = 1'b1;
              MEM_write_address = {addr[31:2], 2'b00};
              MEM_write_data    = st_elem << lane_sh;
              MEM_write_strobe  = strb_base << addr[1:0];
            end else begin
              MEM_read_address = addr;
              buf_d            = ld_buf;
            end
          end
          if (idx_q == vl_q - 32'd1) state_d = S_DONE;
          else                       idx_d   = idx_q + 32'd1;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        error   = err_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
        if (!store_q && !err_q) begin
          VREG_write_enable  = 1'b1;
          VREG_write_address = vd_q;
          VREG_write_data    = buf_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (SYS_reset) begin
      busy               = 1'b0;
      done               = 1'b0;
      error              = 1'b0;
      MEM_read_address   = '0;
      MEM_write_enable   = 1'b0;
      MEM_write_address  = '0;
      MEM_write_data     = '0;
      MEM_write_strobe   = '0;
      VREG_write_enable  = 1'b0;
      VREG_write_address = '0;
      VREG_write_data    = '0;
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: vector table plus reset and busy-start sequences.
module tb_vector_mem_sequencer;
  localparam int unsigned VLEN = 128;

  logic            SYS_clk = 1'b0;
  logic            SYS_reset, start, is_store, vm;
  logic [31:0]     base_address, stride, vl, vstart;
  logic [1:0]      mop;
  logic [4:0]      vreg_address;
  logic [2:0]      vsew;
  logic [VLEN-1:0] v_src, v0_mask;
  logic [31:0]     MEM_read_data;
  logic            busy, done, error;
  logic [31:0]     MEM_read_address, MEM_write_address, MEM_write_data;
  logic            MEM_write_enable, VREG_write_enable;
  logic [3:0]      MEM_write_strobe;
  logic [4:0]      VREG_write_address;
  logic [VLEN-1:0] VREG_write_data;

  logic [31:0] mem [0:255];
  logic        mem_load;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 SYS_clk = ~SYS_clk;

  vector_mem_sequencer #(.VLEN(VLEN)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .start(start), .is_store(is_store),
    .base_address(base_address), .stride(stride), .mop(mop), .vm(vm),
    .vreg_address(vreg_address), .vsew(vsew), .vl(vl), .vstart(vstart),
    .v_src(v_src), .v0_mask(v0_mask), .MEM_read_data(MEM_read_data),
    .busy(busy), .done(done), .error(error), .MEM_read_address(MEM_read_address),
    .MEM_write_enable(MEM_write_enable), .MEM_write_address(MEM_write_address),
    .MEM_write_data(MEM_write_data), .MEM_write_strobe(MEM_write_strobe),
    .VREG_write_enable(VREG_write_enable), .VREG_write_address(VREG_write_address),
    .VREG_write_data(VREG_write_data)
  );

  assign MEM_read_data = mem[MEM_read_address[9:2]];

  always @(posedge SYS_clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5555_5555;
      mem[8'h40] <= 32'h1111_1111;
      mem[8'h41] <= 32'h2222_2222;
      mem[8'h42] <= 32'h3333_3333;
      mem[8'h43] <= 32'h4444_4444;
      mem[8'h80] <= 32'hDDCC_BBAA;
      mem[8'h81] <= 32'h0000_00EE;
    end else if (MEM_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (MEM_write_strobe[b]) mem[MEM_write_address[9:2]][8*b +: 8] <= MEM_write_data[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [31:0] base;
    logic [31:0] strd;
    logic [1:0]  mop;
    logic        vm;
    logic [2:0]  sew;
    logic [31:0] vl;
    logic [31:0] vstart;
    logic [127:0] vsrc;
    logic [127:0] mask;
    int unsigned lat;
    logic        err;
    logic        vwe;
    logic [127:0] vdata;
    int unsigned reads;
    int unsigned writes;
  } vec_t;

  localparam logic [127:0] V = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

  vec_t vecs[14];

  int unsigned  cyc, reads, writes, lat;
  logic         got, busy_bad, g_err, g_vwe;
  logic [127:0] g_vdata;
  logic [4:0]   g_vaddr;

  // Drives one request and observes each cycle until done or the cycle budget runs out.
  task automatic run_req(input vec_t v, input logic [4:0] vd, input logic busy_start);
    @(negedge SYS_clk);
    is_store = v.st; base_address = v.base; stride = v.strd; mop = v.mop; vm = v.vm;
    vsew = v.sew; vl = v.vl; vstart = v.vstart; v_src = v.vsrc; v0_mask = v.mask;
    vreg_address = vd; start = 1'b1;
    @(negedge SYS_clk);
    start = 1'b0;
    cyc = 1; got = 1'b0; reads = 0; writes = 0; lat = 0; busy_bad = 1'b0;
    g_err = 1'b0; g_vwe = 1'b0; g_vdata = '0; g_vaddr = '0;
    while (!got && cyc <= 40) begin
      if (!busy) busy_bad = 1'b1;
      if (MEM_read_address != 32'd0) reads++;
      if (MEM_write_enable) writes++;
      if (done) begin
        got = 1'b1; lat = cyc; g_err = error; g_vwe = VREG_write_enable;
        g_vdata = VREG_write_data; g_vaddr = VREG_write_address;
        start = 1'b0;
      end else begin
        if (busy_start && cyc == 2) begin
          start = 1'b1; is_store = 1'b1; base_address = 32'h300; vl = 32'd1; vstart = 32'd0;
        end
        @(negedge SYS_clk);
        cyc++;
      end
    end
  endtask

  initial begin
    SYS_reset = 1'b1; mem_load = 1'b1; start = 1'b0; is_store = 1'b0; vm = 1'b1;
    base_address = '0; stride = '0; vl = '0; vstart = '0; mop = '0; vreg_address = '0;
    vsew = '0; v_src = '0; v0_mask = '0;

    //             st base      stride        mop    vm sew   vl  vst vsrc  mask    lat err vwe vdata                                     rd wr
    vecs[0]  = '{1'b0, 32'h100, 32'd0,        2'b00, 1'b1, 3'd2, 4,  0, V,    128'h0, 5, 1'b0, 1'b1, 128'h44444444_33333333_22222222_11111111, 4, 0};
    vecs[1]  = '{1'b0, 32'h201, 32'd0,        2'b00, 1'b1, 3'd0, 4,  0, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 128'h0, 5, 1'b0, 1'b1, 128'h0F0E0D0C_0B0A0908_07060504_EEDDCCBB, 4, 0};
    vecs[2]  = '{1'b1, 32'h300, 32'd8,        2'b10, 1'b0, 3'd1, 3,  0, 128'hCCCC_BBBB_AAAA, 128'h5, 4, 1'b0, 1'b0, 128'h0, 0, 2};
    vecs[3]  = '{1'b1, 32'h323, 32'd0,        2'b00, 1'b1, 3'd0, 1,  0, 128'h5A, 128'h0, 2, 1'b0, 1'b0, 128'h0, 0, 1};
    vecs[4]  = '{1'b0, 32'h102, 32'd0,        2'b00, 1'b1, 3'd2, 4,  0, V,    128'h0, 2, 1'b1, 1'b0, 128'h0, 0, 0};
    vecs[5]  = '{1'b0, 32'h100, 32'd0,        2'b00, 1'b1, 3'd3, 4,  0, V,    128'h0, 1, 1'b1, 1'b0, 128'h0, 0, 0};
    vecs[6]  = '{1'b0, 32'h100, 32'd0,        2'b00, 1'b1, 3'd2, 4,  4, V,    128'h0, 1, 1'b0, 1'b1, V, 0, 0};
    vecs[7]  = '{1'b0, 32'h100, 32'd0,        2'b00, 1'b1, 3'd2, 5,  0, V,    128'h0, 1, 1'b1, 1'b0, 128'h0, 0, 0};
    vecs[8]  = '{1'b0, 32'h100, 32'd0,        2'b01, 1'b1, 3'd2, 4,  0, V,    128'h0, 1, 1'b1, 1'b0, 128'h0, 0, 0};
    vecs[9]  = '{1'b0, 32'h100, 32'd0,        2'b00, 1'b1, 3'd2, 4,  2, V,    128'h0, 3, 1'b0, 1'b1, 128'h44444444_33333333_DDDDDDDD_CCCCCCCC, 2, 0};
    vecs[10] = '{1'b0, 32'h10C, 32'hFFFFFFFC, 2'b10, 1'b1, 3'd2, 4,  0, V,    128'h0, 5, 1'b0, 1'b1, 128'h11111111_22222222_33333333_44444444, 4, 0};
    vecs[11] = '{1'b0, 32'h100, 32'd0,        2'b00, 1'b0, 3'd2, 4,  0, V,    128'h6, 5, 1'b0, 1'b1, 128'hFFFFFFFF_33333333_22222222_CCCCCCCC, 2, 0};
    vecs[12] = '{1'b1, 32'h301, 32'd0,        2'b00, 1'b1, 3'd1, 2,  0, V,    128'h0, 2, 1'b1, 1'b0, 128'h0, 0, 0};
    vecs[13] = '{1'b0, 32'h100, 32'd0,        2'b00, 1'b1, 3'd0, 16, 0, V,    128'h0, 17, 1'b0, 1'b1, 128'h44444444_33333333_22222222_11111111, 16, 0};

    repeat (3) @(posedge SYS_clk);
    @(negedge SYS_clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_outs", 128'({error, MEM_write_enable, VREG_write_enable}), 128'd0);
    chk("rst_raddr", 128'(MEM_read_address), 128'd0);
    SYS_reset = 1'b0; mem_load = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_req(vecs[i], 5'(i + 3), 1'b0);
      chk($sformatf("v%0d_done_seen", i), 128'(got), 128'd1);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
      chk($sformatf("v%0d_error", i), 128'(g_err), 128'(vecs[i].err));
      chk($sformatf("v%0d_vreg_we", i), 128'(g_vwe), 128'(vecs[i].vwe));
      if (vecs[i].vwe) begin
        chk($sformatf("v%0d_vreg_data", i), g_vdata, vecs[i].vdata);
        chk($sformatf("v%0d_vreg_addr", i), 128'(g_vaddr), 128'(i + 3));
      end
      chk($sformatf("v%0d_reads", i), 128'(reads), 128'(vecs[i].reads));
      chk($sformatf("v%0d_writes", i), 128'(writes), 128'(vecs[i].writes));
      chk($sformatf("v%0d_busy_run", i), 128'(busy_bad), 128'd0);
      @(negedge SYS_clk);
      chk($sformatf("v%0d_idle_after", i), 128'({busy, done}), 128'd0);
    end

    chk("mem_300", 128'(mem[8'hC0]), 128'h5555AAAA);
    chk("mem_308", 128'(mem[8'hC2]), 128'h55555555);
    chk("mem_310", 128'(mem[8'hC4]), 128'h5555CCCC);
    chk("mem_320_lane3", 128'(mem[8'hC8]), 128'h5A555555);

    // Reset asserted in cycle 2 of a four-element store.
    @(negedge SYS_clk);
    is_store = 1'b1; base_address = 32'h340; stride = '0; mop = 2'b00; vm = 1'b1; vsew = 3'd2;
    vl = 32'd4; vstart = 32'd0; v_src = 128'h4_00000003_00000002_00000001; v0_mask = '0;
    start = 1'b1;
    @(negedge SYS_clk);
    start = 1'b0;
    writes = MEM_write_enable ? 1 : 0;
    @(posedge SYS_clk);
    #1 SYS_reset = 1'b1;
    @(negedge SYS_clk);
    chk("rst_mid_outs", 128'({busy, done, error, MEM_write_enable, VREG_write_enable}), 128'd0);
    chk("rst_mid_waddr", 128'({MEM_write_address, MEM_write_data, MEM_write_strobe}), 128'd0);
    @(posedge SYS_clk);
    #1 SYS_reset = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge SYS_clk);
      if (done || busy) got = 1'b1;
      if (MEM_write_enable) writes++;
    end
    chk("rst_mid_no_done", 128'(got), 128'd0);
    chk("rst_mid_writes", 128'(writes), 128'd1);
    chk("rst_mid_mem0", 128'(mem[8'hD0]), 128'h00000001);
    chk("rst_mid_mem1", 128'(mem[8'hD1]), 128'h55555555);

    // start re-asserted with a store request while busy must be ignored.
    run_req(vecs[0], 5'd9, 1'b1);
    chk("busy_start_latency", 128'(lat), 128'd5);
    chk("busy_start_vreg", g_vdata, 128'h44444444_33333333_22222222_11111111);
    chk("busy_start_vwe", 128'(g_vwe), 128'd1);
    chk("busy_start_writes", 128'(writes), 128'd0);
    @(negedge SYS_clk);
    chk("busy_start_idle", 128'(busy), 128'd0);
    chk("busy_start_mem", 128'(mem[8'hC0]), 128'h5555AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
